// File: rtl/shiftright_sequential.sv
// Multi-cycle 32-bit logical/arithmetic right shifter, one power-of-two stage per clock.
// Define SHIFTRIGHT_EARLY_EXIT_EN to leave SHIFT once the remaining amount bits are all zero.
module shiftright_sequential (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_shift,
  input  logic [31:0] data_operand,
  input  logic [4:0]  ctrl_shiftamt,
  input  logic        ctrl_arith,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] work;
  logic [4:0]  amount;
  logic        fill;
  logic [2:0]  stage;

  logic        stage_bit;
  logic [4:0]  stage_dist;
  logic        last_stage;
  logic [63:0] stage_ext;
  logic [31:0] stage_work;
  logic        start_to_done;

  // Stage 0 applies the 16-bit shift, stage 4 the 1-bit shift.
  always_comb begin
    stage_bit  = 1'b0;
    stage_dist = 5'd0;
    last_stage = 1'b0;
    case (stage)
      3'd0: begin
        stage_bit  = amount[4];
        stage_dist = 5'd16;
`ifdef SHIFTRIGHT_EARLY_EXIT_EN
        last_stage = (amount[3:0] == 4'd0);
`endif
      end
      3'd1: begin
        stage_bit  = amount[3];
        stage_dist = 5'd8;
`ifdef SHIFTRIGHT_EARLY_EXIT_EN
        last_stage = (amount[2:0] == 3'd0);
`endif
      end
      3'd2: begin
        stage_bit  = amount[2];
        stage_dist = 5'd4;
`ifdef SHIFTRIGHT_EARLY_EXIT_EN
        last_stage = (amount[1:0] == 2'd0);
`endif
      end
      3'd3: begin
        stage_bit  = amount[1];
        stage_dist = 5'd2;
`ifdef SHIFTRIGHT_EARLY_EXIT_EN
        last_stage = (amount[0] == 1'b0);
`endif
      end
      default: begin
        stage_bit  = amount[0];
        stage_dist = 5'd1;
        last_stage = 1'b1;
      end
    endcase
  end

  always_comb begin
    stage_ext  = {{32{fill}}, work} >> stage_dist;
    stage_work = stage_bit ? stage_ext[31:0] : work;
  end

  // A zero shift amount skips the SHIFT phase entirely when early exit is built in.
`ifdef SHIFTRIGHT_EARLY_EXIT_EN
  assign start_to_done = (ctrl_shiftamt == 5'd0);
`else
  assign start_to_done = 1'b0;
`endif

  assign data_result = work;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      work           <= 32'd0;
      amount         <= 5'd0;
      fill           <= 1'b0;
      stage          <= 3'd0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (ctrl_shift) begin
            work   <= data_operand;
            amount <= ctrl_shiftamt;
            fill   <= ctrl_arith & data_operand[31];
            stage  <= 3'd0;
            if (start_to_done) begin
              state          <= DONE;
              data_resultRDY <= 1'b1;
              busy           <= 1'b0;
            end else begin
              state          <= SHIFT;
              data_resultRDY <= 1'b0;
              busy           <= 1'b1;
            end
          end else begin
            state          <= IDLE;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
          end
        end
        SHIFT: begin
          work <= stage_work;
          if (last_stage) begin
            state          <= DONE;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
          end else begin
            stage          <= stage + 3'd1;
            data_resultRDY <= 1'b0;
            busy           <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shiftright_sequential.sv
// Self-checking bench for shiftright_sequential: cycle-level reference model plus directed vectors.
// Honours SHIFTRIGHT_EARLY_EXIT_EN the same way the design does.
module tb_shiftright_sequential;

`ifdef SHIFTRIGHT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        ctrl_shift;
  logic [31:0] data_operand;
  logic [4:0]  ctrl_shiftamt;
  logic        ctrl_arith;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shiftright_sequential dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_shift     (ctrl_shift),
    .data_operand   (data_operand),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .ctrl_arith     (ctrl_arith),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] model_result(input logic [31:0] op, input logic [4:0] amt,
                                               input logic ar);
    logic [63:0] ext;
    ext = {{32{ar & op[31]}}, op} >> amt;
    return ext[31:0];
  endfunction

  // Number of SHIFT edges between the accepting edge and the DONE cycle.
  function automatic int exp_lat(input logic [4:0] amt);
    int tz;
    tz = 0;
    if (!EARLY) return 5;
    if (amt == 5'd0) return 0;
    for (int i = 4; i >= 0; i--) if (amt[i]) tz = i;
    return 5 - tz;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: counts down the expected latency per accepted operation.
  logic        m_active;
  logic        m_rdy;
  int          m_left;
  logic [31:0] m_pending;
  logic [31:0] m_result;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active  = 1'b0;
      m_rdy     = 1'b0;
      m_left    = 0;
      m_pending = 32'd0;
      m_result  = 32'd0;
    end else begin
      m_rdy = 1'b0;
      if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          m_active = 1'b0;
          m_rdy    = 1'b1;
          m_result = m_pending;
        end
      end else if (ctrl_shift) begin
        m_pending = model_result(data_operand, ctrl_shiftamt, ctrl_arith);
        if (exp_lat(ctrl_shiftamt) == 0) begin
          m_rdy    = 1'b1;
          m_result = m_pending;
        end else begin
          m_active = 1'b1;
          m_left   = exp_lat(ctrl_shiftamt);
        end
      end
    end
  end

  always @(negedge clock) begin
    checkOutput("model rdy", {31'd0, data_resultRDY}, {31'd0, m_rdy});
    checkOutput("model busy", {31'd0, busy}, {31'd0, m_active});
    if (!m_active) checkOutput("model result", data_result, m_result);
  end

  task automatic wait_rdy(output int k);
    k = 0;
    while (data_resultRDY !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (k >= 20) begin
      errors++;
      $display("[TB] FAIL rdy timeout: got no pulse expected pulse within 20 cycles");
    end
  endtask

  task automatic applyStimulus(input logic [31:0] op, input logic [4:0] amt, input logic ar,
                               input logic [31:0] exp_val, input string name);
    int k;
    @(negedge clock);
    ctrl_shift    = 1'b1;
    data_operand  = op;
    ctrl_shiftamt = amt;
    ctrl_arith    = ar;
    @(negedge clock);
    ctrl_shift = 1'b0;
    wait_rdy(k);
    checkOutput(name, data_result, exp_val);
    checkOutput({name, " latency"}, k, exp_lat(amt));
  endtask

  initial begin
    int k;
    reset         = 1'b1;
    ctrl_shift    = 1'b0;
    data_operand  = 32'd0;
    ctrl_shiftamt = 5'd0;
    ctrl_arith    = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset result", data_result, 32'd0);
    checkOutput("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    applyStimulus(32'h8000_0000, 5'd4, 1'b0, 32'h0800_0000, "srl 4");
    @(negedge clock);
    checkOutput("srl 4 single pulse", {31'd0, data_resultRDY}, 32'd0);
    applyStimulus(32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000, "sra 4");
    applyStimulus(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, "sra 31 neg");
    applyStimulus(32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, "sra 31 pos");
    applyStimulus(32'hDEAD_BEEF, 5'd16, 1'b0, 32'h0000_DEAD, "srl 16");
    applyStimulus(32'hDEAD_BEEF, 5'd0, 1'b0, 32'hDEAD_BEEF, "shift 0");
    applyStimulus(32'hDEAD_BEEF, 5'd8, 1'b0, 32'h00DE_ADBE, "srl 8");
    applyStimulus(32'h8000_0000, 5'd3, 1'b1, 32'hF000_0000, "sra 3");

    // A start raised while SHIFT is in progress must be ignored.
    @(negedge clock);
    ctrl_shift    = 1'b1;
    data_operand  = 32'hAAAA_5555;
    ctrl_shiftamt = 5'd4;
    ctrl_arith    = 1'b0;
    @(negedge clock);
    ctrl_shift = 1'b0;
    @(negedge clock);
    ctrl_shift   = 1'b1;
    data_operand = 32'h1234_5678;
    @(negedge clock);
    ctrl_shift = 1'b0;
    wait_rdy(k);
    checkOutput("ignored start result", data_result, 32'h0AAA_A555);
    checkOutput("ignored start latency", k, exp_lat(5'd4) - 2);

    // Start accepted in the DONE cycle.
    ctrl_shift    = 1'b1;
    data_operand  = 32'h8000_0000;
    ctrl_shiftamt = 5'd4;
    ctrl_arith    = 1'b1;
    @(negedge clock);
    ctrl_shift = 1'b0;
    checkOutput("back-to-back accepted", {31'd0, busy}, {31'd0, exp_lat(5'd4) != 0});
    wait_rdy(k);
    checkOutput("back-to-back result", data_result, 32'hF800_0000);
    checkOutput("back-to-back gap", k + 1, exp_lat(5'd4) + 1);

    // Asynchronous reset mid-operation.
    @(negedge clock);
    ctrl_shift    = 1'b1;
    data_operand  = 32'h1234_5678;
    ctrl_shiftamt = 5'd1;
    ctrl_arith    = 1'b0;
    @(negedge clock);
    ctrl_shift = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    checkOutput("abort result", data_result, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (3) begin
      @(negedge clock);
      checkOutput("abort no pulse", {31'd0, data_resultRDY}, 32'd0);
    end
    reset         = 1'b0;
    ctrl_shift    = 1'b1;
    data_operand  = 32'hFFFF_0000;
    ctrl_shiftamt = 5'd8;
    ctrl_arith    = 1'b0;
    @(negedge clock);
    ctrl_shift = 1'b0;
    wait_rdy(k);
    checkOutput("post-reset result", data_result, 32'h00FF_FF00);
    checkOutput("post-reset latency", k, exp_lat(5'd8));

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shiftright_sequential.md
# shiftright_sequential

Multi-cycle right-shift unit for the processor's ALU/execute stage: the right-shift counterpart of the fixed-distance left-shift stages. It performs logical (srl) or arithmetic (sra) right shifts of a 32-bit operand by 0–31 bits, applying one power-of-two stage (16, 8, 4, 2, 1) per clock. It uses a start/ready handshake like the multi-cycle mult/div units, so the pipeline can stall on it.

## Interface
Parameters: none; widths are fixed at 32-bit data and a 5-bit shift amount.

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; forces IDLE immediately
- ctrl_shift  in  1  start pulse; sampled on the rising edge
- data_operand  in  32  value to shift; captured on an accepted start
- ctrl_shiftamt  in  5  shift distance 0–31; captured on an accepted start
- ctrl_arith  in  1  1 = sra (fill with operand bit 31), 0 = srl (fill with 0); captured on start
- data_result  out  32  shifted value; valid while data_resultRDY = 1, then held until the next accepted start
- data_resultRDY  out  1  one-cycle pulse marking a valid result
- busy  out  1  high in SHIFT state

## Operation
- States: IDLE, SHIFT, DONE.
- Registers:
  - working register W (32 bits)
  - captured amount A (5 bits)
  - captured fill bit F (equal to ctrl_arith & data_operand[31])
  - stage index S (0–4), where S=0 is the 16-bit stage and S=4 is the 1-bit stage
- Start acceptance: ctrl_shift=1 is accepted in IDLE or DONE. On acceptance:
  - W ← data_operand, A ← ctrl_shiftamt, F is captured, S ← 0.
  - Next state is SHIFT.
- ctrl_shift is ignored in SHIFT: no capture, and the operation in flight is unaffected.
- SHIFT, each cycle:
  - If bit A[4−S] is 1, shift W right by 2^(4−S) and fill the vacated MSBs with F; otherwise W is unchanged.
  - S increments.
  - After the S=4 stage, next state is DONE.
- DONE:
  - data_resultRDY = 1 for exactly this one cycle.
  - Next state is IDLE, unless a new start is accepted in this same cycle; that is legal, and the pulse still occurs.
- data_result is driven from W at all times; W changes only in SHIFT or on capture.
- Arithmetic:
  - Result equals {32{F}, W} >> A, truncated to 32 bits.
  - No overflow or exception flags.

## Timing
- Reset values: state IDLE, data_result = 0, data_resultRDY = 0, busy = 0, A = 0, S = 0, F = 0.
- Latency, with E0 as the edge that accepts the start:
  - Without the macro: exactly 5 SHIFT edges (E1–E5) follow; data_resultRDY is high in the cycle after E5.
  - The next start can be accepted on E6 (the DONE cycle edge).
- busy is high from the cycle after E0 through the cycle after E4.
- Back-to-back operation: a start accepted in the DONE cycle gives a sustained rate of one result per 6 cycles.
- Reset asserted mid-operation:
  - The operation aborts immediately and all outputs take their reset values.
  - No data_resultRDY pulse is produced for the aborted operation.
- Reset deassertion: a start is accepted on the first rising edge on which reset is low.

## Configuration
- SHIFTRIGHT_EARLY_EXIT_EN undefined: fixed 5-cycle SHIFT phase for every shift amount.
- SHIFTRIGHT_EARLY_EXIT_EN defined: the unit leaves SHIFT as soon as the remaining lower bits of A are all zero.
  - Latency L = 5 − trailing_zeros(A), with data_resultRDY high in the cycle after E_L.
  - shamt=0 (L=0): capture goes straight to DONE, and data_result = data_operand in the cycle after E0.
  - Examples: shamt=16 gives L=1; shamt=8 gives L=2; shamt=1 gives L=5.
  - busy is high only while in SHIFT.
  - Functional results are identical with or without the macro.

## Test plan
- srl: data_operand=0x80000000, amt=4, arith=0 → data_result=0x08000000; data_resultRDY pulses exactly once, in the cycle after E5.
- sra: data_operand=0x80000000, amt=4 → 0xF8000000; amt=31 → 0xFFFFFFFF. data_operand=0x7FFFFFFF, amt=31, arith=1 → 0x00000000.
- Extremes: data_operand=0xDEADBEEF, amt=16, srl → 0x0000DEAD. amt=0 → 0xDEADBEEF; with the macro, data_resultRDY comes in the cycle after E0.
- Busy handling: a second ctrl_shift (data_operand=0x12345678) at E2 is ignored, and the first result is unaffected. A start issued in the DONE cycle is accepted, and its result follows 6 cycles later.
- Reset: assert reset asynchronously (mid-cycle) at E3 → data_result=0, busy=0, no data_resultRDY. After release, a new operation (0xFFFF0000 srl 8 → 0x00FFFF00) completes normally.
- Early exit (macro defined): amt=8 → data_resultRDY in the cycle after E2. amt=3 → data_resultRDY in the cycle after E5, with the same values as the non-macro build.
